// File: rtl/credit_return_fifo.sv
// Credit-gated return buffer: hands out one credit per free slot, tracks items
// in the external fixed-latency delay line, and buffers what comes back.
module credit_return_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic                       valid_i,
  input  logic [Width-1:0]           data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [Width-1:0]           data_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic [$clog2(Depth+1)-1:0] inflight_o,
  output logic                       err_o
);

  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [CntW-1:0]  inflight_q, inflight_d;
  logic             err_q;

  logic             issue_fire;
  logic             pop;
  logic             wr_en;
  logic             drop;
  logic             unexpected;
  logic             inflight_dec;
  logic [CntW:0]    occupied;

  // Pointers step through 0..Depth-1 only, so non-power-of-two depths wrap cleanly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign occupied      = {1'b0, count_q} + {1'b0, inflight_q};
  assign issue_ready_o = occupied < {1'b0, DepthC};
  assign issue_fire    = issue_valid_i && issue_ready_o;

  assign valid_o = (count_q != '0);
  assign pop     = valid_o && ready_i;

  // A full buffer can still take the return if the head leaves in the same cycle.
  assign wr_en        = valid_i && ((count_q != DepthC) || pop);
  assign drop         = valid_i && !wr_en;
  assign unexpected   = valid_i && (inflight_q == '0);
  assign inflight_dec = valid_i && (inflight_q != '0);

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue_fire, inflight_dec})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q    <= count_d;
      inflight_q <= inflight_d;
      if (drop || unexpected) err_q <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= data_i;
  end

  assign data_o     = valid_o ? mem[rd_ptr_q] : '0;
  assign count_o    = count_q;
  assign inflight_o = inflight_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_credit_return_fifo.sv
// Bench for credit_return_fifo: directed vector table, a Depth=3 steady-state
// sequence and randomized traffic against a queue-based reference model.
module tb_credit_return_fifo;

  localparam int Depth = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni, issue_valid_i, valid_i, ready_i;
  logic [31:0] data_i;
  logic        issue_ready_o, valid_o, err_o;
  logic [31:0] data_o;
  logic [2:0]  count_o, inflight_o;

  logic        rst3_n, iv3, v3, rdy3;
  logic [7:0]  d3;
  logic        irdy3, vo3, err3;
  logic [7:0]  dout3;
  logic [1:0]  cnt3, inf3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  credit_return_fifo #(.Width(32), .Depth(Depth)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .valid_i(valid_i), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .count_o(count_o), .inflight_o(inflight_o), .err_o(err_o)
  );

  credit_return_fifo #(.Width(8), .Depth(3)) dut3 (
    .clk_i(clk_i), .rst_ni(rst3_n),
    .issue_valid_i(iv3), .issue_ready_o(irdy3),
    .valid_i(v3), .data_i(d3),
    .valid_o(vo3), .ready_i(rdy3), .data_o(dout3),
    .count_o(cnt3), .inflight_o(inf3), .err_o(err3)
  );

  typedef struct {
    logic        rst_n, iv, v;
    logic [31:0] d;
    logic        rdy;
    int          cnt, inf;
    logic        irdy, vo;
    logic [31:0] dout;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic iv, logic v, logic [31:0] d, logic rdy,
                              int cnt, int inf, logic irdy, logic vo,
                              logic [31:0] dout, logic err);
    vec_t t;
    t.rst_n = r; t.iv = iv; t.v = v; t.d = d; t.rdy = rdy;
    t.cnt = cnt; t.inf = inf; t.irdy = irdy; t.vo = vo; t.dout = dout; t.err = err;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Reference model: a queue holding buffered data plus an in-flight tally.
  int unsigned mq[$];
  int          m_inf;
  bit          m_err;

  task automatic model_edge(input logic r, input logic iv, input logic v,
                            input logic [31:0] d, input logic rdy);
    bit accept, do_pop;
    if (!r) begin
      mq.delete();
      m_inf = 0;
      m_err = 0;
      return;
    end
    accept = iv && ((Depth - int'(mq.size()) - m_inf) > 0);
    do_pop = (mq.size() > 0) && rdy;
    if (do_pop) void'(mq.pop_front());
    if (v) begin
      if (m_inf == 0) m_err = 1;
      else m_inf--;
      if (mq.size() < Depth) mq.push_back(d);
      else m_err = 1;
    end
    if (accept) m_inf++;
  endtask

  task automatic drive(input logic r, input logic iv, input logic v,
                       input logic [31:0] d, input logic rdy);
    rst_ni = r; issue_valid_i = iv; valid_i = v; data_i = d; ready_i = rdy;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic r, iv, v, rdy;
    logic [31:0] d;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst3_n = 1'b0; iv3 = 1'b0; v3 = 1'b0; d3 = 8'h0; rdy3 = 1'b0;
    tick();
    tick();

    // Back-to-back issues exhaust the credits.
    tbl.push_back(mk(0,0,0,0,0,          0,0,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,          0,1,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,          0,2,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,          0,3,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,          0,4,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,          0,4,0,0,0,0));
    // Latency-3 returns of A..D, held, then drained in order.
    tbl.push_back(mk(0,0,0,0,0,          0,0,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,          0,1,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,          0,2,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,          0,3,1,0,0,0));
    tbl.push_back(mk(1,1,1,32'hA,0,      1,3,0,1,32'hA,0));
    tbl.push_back(mk(1,0,1,32'hB,0,      2,2,0,1,32'hA,0));
    tbl.push_back(mk(1,0,1,32'hC,0,      3,1,0,1,32'hA,0));
    tbl.push_back(mk(1,0,1,32'hD,0,      4,0,0,1,32'hA,0));
    tbl.push_back(mk(1,0,0,0,0,          4,0,0,1,32'hA,0));
    tbl.push_back(mk(1,0,0,0,1,          3,0,1,1,32'hB,0));
    tbl.push_back(mk(1,0,0,0,1,          2,0,1,1,32'hC,0));
    tbl.push_back(mk(1,0,0,0,1,          1,0,1,1,32'hD,0));
    tbl.push_back(mk(1,0,0,0,1,          0,0,1,0,0,0));
    // Unsolicited return after reset.
    tbl.push_back(mk(0,0,0,0,0,          0,0,1,0,0,0));
    tbl.push_back(mk(1,0,1,32'hA5,0,     1,0,1,1,32'hA5,1));
    tbl.push_back(mk(1,0,0,0,1,          0,0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,          0,0,1,0,0,0));
    // Reset mid-operation with count 2, inflight 1.
    tbl.push_back(mk(1,1,0,0,0,          0,1,1,0,0,0));
    tbl.push_back(mk(1,1,1,32'h11,0,     1,1,1,1,32'h11,0));
    tbl.push_back(mk(1,1,1,32'h22,0,     2,1,1,1,32'h11,0));
    tbl.push_back(mk(0,1,1,32'h33,1,     0,0,1,0,0,0));
    // Full buffer drops an extra return and latches the error.
    tbl.push_back(mk(1,1,0,0,0,          0,1,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,          0,2,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,          0,3,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,          0,4,0,0,0,0));
    tbl.push_back(mk(1,0,1,32'hA1,0,     1,3,0,1,32'hA1,0));
    tbl.push_back(mk(1,0,1,32'hA2,0,     2,2,0,1,32'hA1,0));
    tbl.push_back(mk(1,0,1,32'hA3,0,     3,1,0,1,32'hA1,0));
    tbl.push_back(mk(1,0,1,32'hA4,0,     4,0,0,1,32'hA1,0));
    tbl.push_back(mk(1,0,1,32'hBB,0,     4,0,0,1,32'hA1,1));
    tbl.push_back(mk(1,0,0,0,0,          4,0,0,1,32'hA1,1));
    tbl.push_back(mk(1,0,0,0,1,          3,0,1,1,32'hA2,1));
    tbl.push_back(mk(1,0,0,0,1,          2,0,1,1,32'hA3,1));
    tbl.push_back(mk(1,0,0,0,1,          1,0,1,1,32'hA4,1));
    tbl.push_back(mk(1,0,0,0,1,          0,0,1,0,0,1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].iv, tbl[i].v, tbl[i].d, tbl[i].rdy);
      tick();
      chk("tbl_count",    i, 32'(count_o),    32'(tbl[i].cnt));
      chk("tbl_inflight", i, 32'(inflight_o), 32'(tbl[i].inf));
      chk("tbl_ready",    i, 32'(issue_ready_o), 32'(tbl[i].irdy));
      chk("tbl_valid",    i, 32'(valid_o),    32'(tbl[i].vo));
      chk("tbl_data",     i, data_o,          tbl[i].dout);
      chk("tbl_err",      i, 32'(err_o),      32'(tbl[i].err));
    end

    // Randomized traffic against the reference model.
    model_edge(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) != 0);
      iv  = $urandom_range(0, 1) == 1;
      v   = (m_inf > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      d   = $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      model_edge(r, iv, v, d, rdy);
      drive(r, iv, v, d, rdy);
      tick();
      chk("rnd_count",    i, 32'(count_o),       mq.size());
      chk("rnd_inflight", i, 32'(inflight_o),    32'(m_inf));
      chk("rnd_ready",    i, 32'(issue_ready_o), 32'((Depth - int'(mq.size()) - m_inf) > 0));
      chk("rnd_valid",    i, 32'(valid_o),       32'(mq.size() > 0));
      chk("rnd_data",     i, data_o,             (mq.size() > 0) ? mq[0] : 32'h0);
      chk("rnd_err",      i, 32'(err_o),         32'(m_err));
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Depth=3 steady state: issue, return and pop every cycle.
    rst3_n = 1'b0; tick();
    rst3_n = 1'b1; iv3 = 1'b1; tick();
    chk("d3_setup_inf", 0, 32'(inf3), 32'd1);
    v3 = 1'b1; d3 = 8'h10; tick();
    chk("d3_setup_cnt", 0, 32'(cnt3), 32'd1);
    chk("d3_setup_data", 0, 32'(dout3), 32'h10);
    for (int k = 1; k <= 10; k++) begin
      d3 = 8'(8'h10 + k); rdy3 = 1'b1;
      tick();
      chk("d3_count",    k, 32'(cnt3),  32'd1);
      chk("d3_inflight", k, 32'(inf3),  32'd1);
      chk("d3_ready",    k, 32'(irdy3), 32'd1);
      chk("d3_valid",    k, 32'(vo3),   32'd1);
      chk("d3_data",     k, 32'(dout3), 32'(8'h10 + k));
      chk("d3_err",      k, 32'(err3),  32'd0);
    end
    iv3 = 1'b0; v3 = 1'b0; rdy3 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
